// File: rtl/mult_div_pkg.sv
// Shared constants and helpers for the iterative signed multiply/divide unit.
// Configuration macro consumed by the unit: DIV_ZERO_EXC_EN.
package mult_div_pkg;

  localparam int WIDTH      = 32;
  localparam int ITER_COUNT = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MULT = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] val);
    return neg ? (~val + 1'b1) : val;
  endfunction

endpackage

// File: rtl/mult_div_sign_fix.sv
// Combinational sign handling for division: operand magnitudes in, signed results out.
// Zero latency; no flow control.
module mult_div_sign_fix
  import mult_div_pkg::*;
(
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] rem_i,
  input  logic             q_neg_i,
  input  logic             r_neg_i,
  output logic [WIDTH-1:0] a_mag_o,
  output logic [WIDTH-1:0] b_mag_o,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o
);

  // The most negative value maps onto itself, which is its correct unsigned magnitude.
  assign a_mag_o = cond_neg(a_i[WIDTH-1], a_i);
  assign b_mag_o = cond_neg(b_i[WIDTH-1], b_i);
  assign quo_o   = cond_neg(q_neg_i, quo_i);
  assign rem_o   = cond_neg(r_neg_i, rem_i);

endmodule

// File: rtl/mult_div.sv
// Iterative signed 32x32 multiply (radix-2 Booth) / restoring divide; DIV_ZERO_EXC_EN enables zero-divisor trap.
// Result 33 cycles after accept (done pulse); starts while busy are dropped, no other backpressure.
module mult_div #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);
  import mult_div_pkg::*;

  logic [1:0]       state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d, mcand_q, mcand_d, hi_q, hi_d, lo_q, lo_d;
  logic             qm1_q, qm1_d, q_neg_q, q_neg_d, r_neg_q, r_neg_d;

  logic             last_step, div_by_zero_exc, div_ge;
  logic [WIDTH:0]   mcand_ext, booth_sum, rem_sh, rem_next;
  logic [WIDTH+1:0] rem_diff;
  logic [2*WIDTH+1:0] booth_sh;
  logic [WIDTH-1:0] quo_next, a_mag, b_mag, quo_fix, rem_fix;

  assign last_step = (cnt_q == 6'(ITER_COUNT - 1));

`ifdef DIV_ZERO_EXC_EN
  logic div_zero_q, div_zero_d;
  assign div_by_zero_exc = (b_in == '0);
  assign div_zero_d = ((state_q == ST_IDLE) || (state_q == ST_DONE))
                      && !start_mult && start_div && div_by_zero_exc;
  always_ff @(posedge clock) begin
    if (reset) div_zero_q <= 1'b0;
    else       div_zero_q <= div_zero_d;
  end
  assign div_zero = div_zero_q;
`else
  assign div_by_zero_exc = 1'b0;
  assign div_zero        = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_mult)     state_d = ST_MULT;
        else if (start_div) state_d = div_by_zero_exc ? ST_DONE : ST_DIV;
        else                state_d = ST_IDLE;
      end
      ST_MULT, ST_DIV: if (last_step) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_MULT) || (state_q == ST_DIV);
    done = (state_q == ST_DONE);
  end

  // Booth step: 33-bit accumulator absorbs the +/- 2^31 multiplicand without overflow.
  assign mcand_ext = {mcand_q[WIDTH-1], mcand_q};
  always_comb begin
    booth_sum = acc_q;
    case ({mq_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + mcand_ext;
      2'b10:   booth_sum = acc_q - mcand_ext;
      default: booth_sum = acc_q;
    endcase
  end
  assign booth_sh = {booth_sum[WIDTH], booth_sum, mq_q};

  assign rem_sh   = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
  assign rem_diff = {1'b0, rem_sh} - {2'b00, mcand_q};
  assign div_ge   = ~rem_diff[WIDTH+1];
  assign rem_next = div_ge ? rem_diff[WIDTH:0] : rem_sh;
  assign quo_next = {mq_q[WIDTH-2:0], div_ge};

  mult_div_sign_fix u_sign_fix (
    .a_i     (a_in),
    .b_i     (b_in),
    .quo_i   (quo_next),
    .rem_i   (rem_next[WIDTH-1:0]),
    .q_neg_i (q_neg_q),
    .r_neg_i (r_neg_q),
    .a_mag_o (a_mag),
    .b_mag_o (b_mag),
    .quo_o   (quo_fix),
    .rem_o   (rem_fix)
  );

  always_comb begin
    acc_d   = acc_q;
    mq_d    = mq_q;
    mcand_d = mcand_q;
    qm1_d   = qm1_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_mult) begin
          acc_d   = '0;
          mq_d    = b_in;
          mcand_d = a_in;
          qm1_d   = 1'b0;
          cnt_d   = '0;
        end else if (start_div && !div_by_zero_exc) begin
          acc_d   = '0;
          mq_d    = a_mag;
          mcand_d = b_mag;
          q_neg_d = a_in[WIDTH-1] ^ b_in[WIDTH-1];
          r_neg_d = a_in[WIDTH-1];
          cnt_d   = '0;
        end
      end
      ST_MULT: begin
        acc_d = booth_sh[2*WIDTH+1:WIDTH+1];
        mq_d  = booth_sh[WIDTH:1];
        qm1_d = booth_sh[0];
        cnt_d = cnt_q + 6'd1;
        if (last_step) begin
          hi_d = booth_sh[2*WIDTH:WIDTH+1];
          lo_d = booth_sh[WIDTH:1];
        end
      end
      ST_DIV: begin
        acc_d = rem_next;
        mq_d  = quo_next;
        cnt_d = cnt_q + 6'd1;
        if (last_step) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_d_reset: begin
        acc_q   <= '0;
        mq_q    <= '0;
        mcand_q <= '0;
        qm1_q   <= 1'b0;
        q_neg_q <= 1'b0;
        r_neg_q <= 1'b0;
        cnt_q   <= '0;
        hi_q    <= '0;
        lo_q    <= '0;
      end
    end else begin
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      mcand_q <= mcand_d;
      qm1_q   <= qm1_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule
